// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: fetch PC, imem request issue,
// and a small {pc, instr} FIFO presented to decode.
module instr_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW+1:0] LVL_MAX = (AW+2)'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t        fifo_q [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_nxt;
   logic [AW+1:0] level;
   logic [31:0]   fetch_pc;
   logic [31:0]   inflight_pc;
   logic          inflight;
   logic          push;
   logic          pop;
   logic          issue;

   // Credit check counts the in-flight word so a push never hits a full FIFO.
   always_comb begin
      level = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
      issue = !reset && !redirect_valid && (level < LVL_MAX);
      push  = inflight && !redirect_valid;
      pop   = out_valid && out_ready;
   end

   assign imem_req  = issue;
   assign imem_addr = fetch_pc;
   assign out_valid = (count != '0);
   assign out_instr = fifo_q[rd_ptr].instr;
   assign out_pc    = fifo_q[rd_ptr].pc;

   // Occupancy next-state; a redirect empties the queue after any pop.
   always_comb begin
      count_nxt = count;
      if (redirect_valid) begin
         count_nxt = '0;
      end else begin
         unique case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
         endcase
      end
   end

   // Fetch PC and outstanding-request tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_pc & 32'hFFFF_FFFC;
         inflight    <= 1'b0;
      end else if (issue) begin
         fetch_pc    <= fetch_pc + 32'd4;
         inflight    <= 1'b1;
         inflight_pc <= fetch_pc;
      end else begin
         inflight    <= 1'b0;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_nxt;
         if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr] <= '{pc: inflight_pc, instr: imem_rdata};
      end
   end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front end for the CPU core. Owns the fetch program counter, issues word reads to the synchronous instruction memory, buffers returned instructions with their PCs in a small FIFO, and presents them to decode (control unit, immediate generator, register file) through a valid/ready handshake. A redirect input flushes the queue and restarts fetch at a new PC for branches and jumps.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥4.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `imem_req` out 1: read request this cycle.
- `imem_addr` out 32: byte address of the requested word; bits [1:0] always 0.
- `imem_rdata` in 32: instruction word; valid exactly one cycle after the cycle `imem_req`=1.
- `redirect_valid` in 1: flush and restart fetch.
- `redirect_pc` in 32: restart address; bits [1:0] ignored (treated as 0).
- `out_valid` out 1: head entry valid.
- `out_instr` out 32: head instruction.
- `out_pc` out 32: PC of head instruction.
- `out_ready` in 1: decode accepts head this cycle.

## Operation
- State: `fetch_pc` (32), `inflight` (1), FIFO of DEPTH × {pc, instr}, read/write pointers of log2(DEPTH) bits, `count` of log2(DEPTH)+1 bits.
- Issue: `imem_req` = !redirect_valid && (count + inflight < DEPTH). `imem_addr` = `fetch_pc`. On issue: `fetch_pc` += 4 (mod 2^32), `inflight` ← 1, `inflight_pc` ← `fetch_pc`; otherwise `inflight` ← 0.
- Response: when `inflight`=1 and no redirect this cycle, push {`inflight_pc`, `imem_rdata`}. Credit rule guarantees push never occurs when full.
- Pop: `out_valid && out_ready` advances the read pointer. Push and pop in the same cycle leave `count` unchanged.
- `out_valid` = (count ≠ 0); `out_instr`/`out_pc` driven from the head entry; no bypass from `imem_rdata`.
- Redirect (`redirect_valid`=1): a pop in the same cycle completes (decode consumed it); then count ← 0, pointers ← 0, `inflight` ← 0 (pending response discarded), `fetch_pc` ← {redirect_pc[31:2], 2'b00}; no request issued this cycle.
- Pointers wrap modulo DEPTH.
- Reset (any time, including mid-burst): `fetch_pc` ← RESET_PC, `inflight` ← 0, count ← 0, pointers ← 0. Reset overrides redirect.

## Timing
- Reset values: `imem_req`=0 while `reset`=1, `imem_addr`=RESET_PC, `out_valid`=0, `out_instr`/`out_pc` don't-care while `out_valid`=0.
- First request in first cycle after `reset` deasserts.
- Latency: request at cycle N → push at end of N+1 → `out_valid` at N+2.
- Redirect at cycle R → request to redirect target at R+1 → `out_valid` at R+3.
- Throughput: one instruction per cycle sustained with `out_ready` held high (DEPTH ≥ 3 suffices for full rate).
- Backpressure: with `out_ready`=0, requests stop once count + inflight = DEPTH; `out_instr`/`out_pc` hold stable while `out_valid && !out_ready`.

## Test plan
- Reset release, `out_ready`=1: `imem_addr` sequence 0x0, 0x4, 0x8…; first `out_valid` 2 cycles after first req with `out_pc`=0x0, then one entry per cycle in order.
- `out_ready`=0 from start: exactly 4 requests (0x0–0xC), then `imem_req`=0; raising `out_ready` drains 0x0, 0x4, 0x8, 0xC in order and fetch resumes at 0x10.
- Redirect to 0x100 while 3 entries queued and one in flight: next cycle `out_valid`=0, stale response dropped, next req 0x100, first output `out_pc`=0x100; `redirect_pc`=0x103 yields 0x100.
- Redirect in same cycle as accepted pop: popped entry counted consumed exactly once; no stale PC appears afterwards.
- `fetch_pc` wrap: redirect to 0xFFFF_FFFC → requests 0xFFFF_FFFC, 0x0000_0000.
- Assert `reset` mid-stream with full FIFO: `out_valid` drops immediately (asynchronous), after release fetch restarts at RESET_PC.
